// File: rtl/ethernet_encapsulation_if.sv
// ethernet_encapsulation_if
//   Payload byte stream from the MAC client into the GMII TX framer.
//   s_data  : payload byte (client -> framer)
//   s_valid : s_data is valid (client -> framer)
//   s_ready : framer consumes s_data this cycle (framer -> client)
//   master modport: client side; slave modport: framer side.
interface ethernet_encapsulation_if;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/ethernet_encapsulation.sv
// ethernet_encapsulation
//   GMII transmit-side framer. Takes a payload length plus a byte stream and
//   emits one 802.3 length-type frame: preamble, SFD, destination MAC, source
//   MAC, length, payload, optional pad, FCS, then an enforced inter-frame gap.
//
// Ports:
//   clk, rst      byte clock; synchronous active-high reset
//   tx_start      frame request, sampled only while tx_busy=0
//   tx_len[15:0]  payload length, latched with an accepted tx_start
//   tx_busy       high from accept until the inter-frame gap completes
//   len_err       one-cycle pulse when tx_len exceeds MAX_PAYLOAD
//   s (slave)     payload stream: s_data, s_valid in; s_ready out
//   gmii_txd/gmii_tx_en/gmii_tx_er  registered GMII transmit outputs
//   underrun_err  one-cycle pulse, aligned with the error byte on GMII
//   frame_done    one-cycle pulse, aligned with the last FCS byte on GMII
//
// Build option:
//   ETH_TX_PAD_EN  when defined, payloads shorter than MIN_PAYLOAD are
//                  padded with 8'h00 (covered by the FCS). When undefined,
//                  short frames go straight from payload/length to FCS.
module ethernet_encapsulation #(
  parameter logic [47:0] DEST_MAC    = 48'h023528fbdd66,
  parameter logic [47:0] SRC_MAC     = 48'h072227acdb65,
  parameter int unsigned MIN_PAYLOAD = 46,
  parameter int unsigned MAX_PAYLOAD = 1500,
  parameter int unsigned IFG_BYTES   = 12
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            tx_start,
  input  logic [15:0]                     tx_len,
  output logic                            tx_busy,
  output logic                            len_err,
  ethernet_encapsulation_if.slave         s,
  output logic [7:0]                      gmii_txd,
  output logic                            gmii_tx_en,
  output logic                            gmii_tx_er,
  output logic                            underrun_err,
  output logic                            frame_done
);

  if (MAX_PAYLOAD > 32'd65535 || MIN_PAYLOAD > MAX_PAYLOAD || IFG_BYTES == 0) begin : g_cfg_check
    $error("ethernet_encapsulation: inconsistent payload/IFG parameters");
  end

  typedef enum logic [3:0] {
    ST_IDLE, ST_PREAMBLE, ST_SFD, ST_DEST, ST_SRC, ST_LEN,
    ST_PAYLOAD, ST_PAD, ST_FCS, ST_IFG
  } state_t;

  state_t      state, state_d;
  logic [15:0] cnt, cnt_d;
  logic [15:0] len_q, len_d;
  logic [31:0] crc, crc_d;
  logic [31:0] fcs;
  logic        crc_upd;
  logic [7:0]  txd_d;
  logic        en_d, er_d, und_d, done_d, lerr_d;
  state_t      data_done_st;

  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int unsigned i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

  // Byte idx of a MAC address, most-significant byte first.
  function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [2:0] idx);
    logic [47:0] sh;
    sh = mac << (8 * idx);
    return sh[47:40];
  endfunction

`ifdef ETH_TX_PAD_EN
  logic [15:0] pad_len;
  logic        pad_needed;
  assign pad_needed   = len_q < 16'(MIN_PAYLOAD);
  assign pad_len      = 16'(MIN_PAYLOAD) - len_q;
  assign data_done_st = pad_needed ? ST_PAD : ST_FCS;
`else
  assign data_done_st = ST_FCS;
`endif

  assign fcs       = ~crc;
  assign tx_busy   = (state != ST_IDLE);
  assign s.s_ready = (state == ST_PAYLOAD);

  always_comb begin
    state_d = state;
    cnt_d   = cnt + 16'd1;
    len_d   = len_q;
    crc_d   = crc;
    crc_upd = 1'b0;
    txd_d   = '0;
    en_d    = 1'b0;
    er_d    = 1'b0;
    und_d   = 1'b0;
    done_d  = 1'b0;
    lerr_d  = 1'b0;

    case (state)
      ST_IDLE: begin
        cnt_d = '0;
        if (tx_start) begin
          if (tx_len > 16'(MAX_PAYLOAD)) begin
            lerr_d = 1'b1;
          end else begin
            // The accept cycle already launches preamble byte 0 so it is on
            // the wire one cycle later; PREAMBLE then covers the other six.
            len_d   = tx_len;
            state_d = ST_PREAMBLE;
            txd_d   = 8'h55;
            en_d    = 1'b1;
          end
        end
      end
      ST_PREAMBLE: begin
        txd_d = 8'h55;
        en_d  = 1'b1;
        if (cnt == 16'd5) begin
          state_d = ST_SFD;
          cnt_d   = '0;
        end
      end
      ST_SFD: begin
        txd_d   = 8'hD5;
        en_d    = 1'b1;
        crc_d   = '1;
        state_d = ST_DEST;
        cnt_d   = '0;
      end
      ST_DEST: begin
        txd_d   = mac_byte(DEST_MAC, cnt[2:0]);
        en_d    = 1'b1;
        crc_upd = 1'b1;
        if (cnt == 16'd5) begin
          state_d = ST_SRC;
          cnt_d   = '0;
        end
      end
      ST_SRC: begin
        txd_d   = mac_byte(SRC_MAC, cnt[2:0]);
        en_d    = 1'b1;
        crc_upd = 1'b1;
        if (cnt == 16'd5) begin
          state_d = ST_LEN;
          cnt_d   = '0;
        end
      end
      ST_LEN: begin
        txd_d   = cnt[0] ? len_q[7:0] : len_q[15:8];
        en_d    = 1'b1;
        crc_upd = 1'b1;
        if (cnt == 16'd1) begin
          state_d = (len_q != '0) ? ST_PAYLOAD : data_done_st;
          cnt_d   = '0;
        end
      end
      ST_PAYLOAD: begin
        en_d = 1'b1;
        if (s.s_valid) begin
          txd_d   = s.s_data;
          crc_upd = 1'b1;
          if (cnt == len_q - 16'd1) begin
            state_d = data_done_st;
            cnt_d   = '0;
          end
        end else begin
          // Underrun: poison the frame and skip straight to the gap.
          er_d    = 1'b1;
          und_d   = 1'b1;
          state_d = ST_IFG;
          cnt_d   = '0;
        end
      end
`ifdef ETH_TX_PAD_EN
      ST_PAD: begin
        en_d    = 1'b1;
        crc_upd = 1'b1;
        if (cnt == pad_len - 16'd1) begin
          state_d = ST_FCS;
          cnt_d   = '0;
        end
      end
`endif
      ST_FCS: begin
        txd_d = 8'(fcs >> (8 * cnt[1:0]));
        en_d  = 1'b1;
        if (cnt == 16'd3) begin
          done_d  = 1'b1;
          state_d = ST_IFG;
          cnt_d   = '0;
        end
      end
      ST_IFG: begin
        if (cnt == 16'(IFG_BYTES - 1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    if (crc_upd) crc_d = crc32_byte(crc, txd_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      len_q        <= '0;
      crc          <= '1;
      gmii_txd     <= '0;
      gmii_tx_en   <= 1'b0;
      gmii_tx_er   <= 1'b0;
      underrun_err <= 1'b0;
      frame_done   <= 1'b0;
      len_err      <= 1'b0;
    end else begin
      state        <= state_d;
      cnt          <= cnt_d;
      len_q        <= len_d;
      crc          <= crc_d;
      gmii_txd     <= txd_d;
      gmii_tx_en   <= en_d;
      gmii_tx_er   <= er_d;
      underrun_err <= und_d;
      frame_done   <= done_d;
      len_err      <= lerr_d;
    end
  end

endmodule

// File: tb/tb_ethernet_encapsulation.sv
// tb_ethernet_encapsulation
//   Self-checking bench for the GMII TX framer: a table of directed frames,
//   hand-written reset/reject/back-to-back sequences, and random frames, all
//   compared byte-for-byte against a frame model built from the 802.3 layout.
module tb_ethernet_encapsulation;

  localparam logic [47:0] DEST = 48'h023528fbdd66;
  localparam logic [47:0] SRC  = 48'h072227acdb65;
  localparam int MINP = 46;
  localparam int MAXP = 1500;
  localparam int IFG  = 12;
`ifdef ETH_TX_PAD_EN
  localparam bit PADDED = 1'b1;
`else
  localparam bit PADDED = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tx_start = 1'b0;
  logic [15:0] tx_len = '0;
  logic        tx_busy, len_err;
  logic [7:0]  gmii_txd;
  logic        gmii_tx_en, gmii_tx_er, underrun_err, frame_done;

  ethernet_encapsulation_if s_if();

  ethernet_encapsulation #(
    .DEST_MAC(DEST), .SRC_MAC(SRC), .MIN_PAYLOAD(MINP),
    .MAX_PAYLOAD(MAXP), .IFG_BYTES(IFG)
  ) dut (
    .clk(clk), .rst(rst), .tx_start(tx_start), .tx_len(tx_len),
    .tx_busy(tx_busy), .len_err(len_err), .s(s_if),
    .gmii_txd(gmii_txd), .gmii_tx_en(gmii_tx_en), .gmii_tx_er(gmii_tx_er),
    .underrun_err(underrun_err), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [7:0] pay_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  typedef struct {
    int len;
    int drop_at;
    int pat;
    int exp_bytes;
    bit exp_len_err;
  } vec_t;
  vec_t tbl[10];

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Bit-serial reflected CRC-32 over exp_q[from..end], zlib style.
  function automatic logic [31:0] ref_crc(input int from);
    logic [31:0] c;
    logic        fb;
    c = '1;
    for (int i = from; i < exp_q.size(); i++) begin
      for (int b = 0; b < 8; b++) begin
        fb = c[0] ^ exp_q[i][b];
        c  = c >> 1;
        if (fb) c = c ^ 32'hEDB88320;
      end
    end
    return c;
  endfunction

  task automatic build_expected(input int len, input int drop_at);
    logic [47:0] m;
    logic [15:0] ln;
    logic [31:0] f;
    exp_q.delete();
    repeat (7) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    m = DEST;
    for (int i = 0; i < 6; i++) exp_q.push_back(m[47-8*i -: 8]);
    m = SRC;
    for (int i = 0; i < 6; i++) exp_q.push_back(m[47-8*i -: 8]);
    ln = 16'(len);
    exp_q.push_back(ln[15:8]);
    exp_q.push_back(ln[7:0]);
    if (drop_at >= 0) begin
      for (int i = 0; i < drop_at; i++) exp_q.push_back(pay_q[i]);
      exp_q.push_back(8'h00);
    end else begin
      for (int i = 0; i < len; i++) exp_q.push_back(pay_q[i]);
      if (PADDED) for (int i = len; i < MINP; i++) exp_q.push_back(8'h00);
      f = ~ref_crc(8);
      for (int i = 0; i < 4; i++) exp_q.push_back(f[8*i +: 8]);
    end
  endtask

  // Sends one frame from an idle cycle and checks it, the gap and the pulses.
  task automatic send_frame(input int len, input int drop_at, input int pat,
                            input int exp_len, input string tag);
    int  idx, done_cnt, done_pos, er_cnt, er_pos, und_cnt, n, ifg_en, mism, first;
    bit  hs, ended;
    pay_q.delete();
    for (int i = 0; i < len; i++) pay_q.push_back(pat != 0 ? 8'(i) : 8'($urandom));
    build_expected(len, drop_at);
    got_q.delete();
    idx = 0; done_cnt = 0; done_pos = -1; er_cnt = 0; er_pos = -1; und_cnt = 0;
    ended = 1'b0;
    tx_start = 1'b1;
    tx_len = 16'(len);
    s_if.s_valid = (len > 0) && (drop_at != 0);
    s_if.s_data = (len > 0) ? pay_q[0] : 8'h00;
    step();
    tx_start = 1'b0;
    tx_len = 16'($urandom);
    check($sformatf("%s/busy_after_accept", tag), tx_busy, 1);
    for (int cyc = 0; cyc < 3000 && !ended; cyc++) begin
      if (gmii_tx_en) begin
        got_q.push_back(gmii_txd);
        if (gmii_tx_er) begin
          er_cnt++;
          er_pos = got_q.size() - 1;
        end
      end else begin
        ended = 1'b1;
      end
      if (frame_done) begin
        done_cnt++;
        done_pos = got_q.size();
      end
      if (underrun_err) und_cnt++;
      if (!ended) begin
        s_if.s_valid = (idx < len) && (idx != drop_at);
        s_if.s_data = (idx < len) ? pay_q[idx] : 8'($urandom);
        hs = s_if.s_ready && s_if.s_valid;
        step();
        if (hs) idx++;
      end
    end
    s_if.s_valid = 1'b0;
    check($sformatf("%s/tx_en_fell", tag), ended, 1);
    n = 0;
    ifg_en = 0;
    while (tx_busy && n < 100) begin
      if (gmii_tx_en) ifg_en++;
      n++;
      step();
    end
    if (gmii_tx_en) ifg_en++;
    check($sformatf("%s/ifg_busy_cycles", tag), n, IFG - 1);
    check($sformatf("%s/ifg_tx_en", tag), ifg_en, 0);
    check($sformatf("%s/wire_len", tag), got_q.size(), exp_len);
    check($sformatf("%s/model_len", tag), got_q.size(), exp_q.size());
    mism = 0;
    first = -1;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      if (got_q[i] != exp_q[i]) begin
        mism++;
        if (first < 0) first = i;
      end
    end
    check($sformatf("%s/bytes_bad_from_%0d", tag, first), mism, 0);
    if (drop_at >= 0) begin
      check($sformatf("%s/done_cnt", tag), done_cnt, 0);
      check($sformatf("%s/underrun_cnt", tag), und_cnt, 1);
      check($sformatf("%s/er_cnt", tag), er_cnt, 1);
      check($sformatf("%s/er_pos", tag), er_pos, exp_q.size() - 1);
    end else begin
      check($sformatf("%s/done_cnt", tag), done_cnt, 1);
      check($sformatf("%s/done_pos", tag), done_pos, exp_q.size());
      check($sformatf("%s/underrun_cnt", tag), und_cnt, 0);
      check($sformatf("%s/er_cnt", tag), er_cnt, 0);
    end
  endtask

  task automatic reject(input int len, input string tag);
    tx_start = 1'b1;
    tx_len = 16'(len);
    step();
    tx_start = 1'b0;
    check($sformatf("%s/len_err", tag), len_err, 1);
    check($sformatf("%s/busy", tag), tx_busy, 0);
    check($sformatf("%s/tx_en", tag), gmii_tx_en, 0);
    step();
    check($sformatf("%s/len_err_once", tag), len_err, 0);
    check($sformatf("%s/busy_later", tag), tx_busy, 0);
    check($sformatf("%s/tx_en_later", tag), gmii_tx_en, 0);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog expired actual=timeout required=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int taken, n, r1, g, r2, i, flen, drop, len;
    bit hs;
    bit en_log[300];

    tbl[0] = '{46,   -1, 1, 72, 1'b0};
    tbl[1] = '{10,   -1, 0, PADDED ? 72 : 36, 1'b0};
    tbl[2] = '{0,    -1, 0, PADDED ? 72 : 26, 1'b0};
    tbl[3] = '{1,    -1, 0, PADDED ? 72 : 27, 1'b0};
    tbl[4] = '{45,   -1, 0, PADDED ? 72 : 71, 1'b0};
    tbl[5] = '{47,   -1, 0, 73, 1'b0};
    tbl[6] = '{1501, -1, 0, 0, 1'b1};
    tbl[7] = '{1500, -1, 0, 1526, 1'b0};
    tbl[8] = '{60,    5, 0, 28, 1'b0};
    tbl[9] = '{65535,-1, 0, 0, 1'b1};

    s_if.s_valid = 1'b0;
    s_if.s_data = '0;
    repeat (3) step();
    rst = 1'b0;
    check("reset/tx_en", gmii_tx_en, 0);
    check("reset/tx_er", gmii_tx_er, 0);
    check("reset/txd", gmii_txd, 0);
    check("reset/busy", tx_busy, 0);
    check("reset/len_err", len_err, 0);
    check("reset/underrun", underrun_err, 0);
    check("reset/done", frame_done, 0);
    check("reset/s_ready", s_if.s_ready, 0);
    step();

    for (int k = 0; k < 10; k++) begin
      if (tbl[k].exp_len_err) reject(tbl[k].len, $sformatf("vec%0d", k));
      else send_frame(tbl[k].len, tbl[k].drop_at, tbl[k].pat, tbl[k].exp_bytes,
                      $sformatf("vec%0d", k));
    end

    // Reset in the middle of a payload, then a normal frame.
    tx_start = 1'b1;
    tx_len = 16'd60;
    s_if.s_valid = 1'b1;
    step();
    tx_start = 1'b0;
    taken = 0;
    for (int cyc = 0; cyc < 200 && taken < 20; cyc++) begin
      s_if.s_data = 8'($urandom);
      hs = s_if.s_ready;
      step();
      if (hs) taken++;
    end
    check("midrst/reached_byte20", taken, 20);
    rst = 1'b1;
    step();
    rst = 1'b0;
    s_if.s_valid = 1'b0;
    check("midrst/tx_en", gmii_tx_en, 0);
    check("midrst/busy", tx_busy, 0);
    send_frame(30, -1, 0, PADDED ? 72 : 56, "after_rst");

    // Back-to-back with tx_start held high.
    tx_start = 1'b1;
    tx_len = 16'd20;
    s_if.s_valid = 1'b1;
    step();
    for (int k = 0; k < 300; k++) begin
      en_log[k] = gmii_tx_en;
      s_if.s_data = 8'($urandom);
      step();
    end
    tx_start = 1'b0;
    n = 0;
    while (tx_busy && n < 400) begin
      n++;
      step();
    end
    s_if.s_valid = 1'b0;
    check("b2b/drained", tx_busy, 0);
    i = 0; r1 = 0; g = 0; r2 = 0;
    while (i < 300 && en_log[i]) begin r1++; i++; end
    while (i < 300 && !en_log[i]) begin g++; i++; end
    while (i < 300 && en_log[i]) begin r2++; i++; end
    flen = PADDED ? 72 : 46;
    check("b2b/frame1_len", r1, flen);
    check("b2b/gap", g, IFG);
    check("b2b/frame2_len", r2, flen);

    // Random frames against the model.
    for (int k = 0; k < 30; k++) begin
      if ($urandom_range(0, 9) == 0) begin
        reject($urandom_range(MAXP + 1, 65535), $sformatf("rnd%0d", k));
      end else begin
        len = $urandom_range(0, 120);
        drop = (len > 0 && $urandom_range(0, 4) == 0) ? $urandom_range(0, len - 1) : -1;
        if (drop >= 0) flen = 22 + drop + 1;
        else flen = 8 + 14 + ((PADDED && len < MINP) ? MINP : len) + 4;
        send_frame(len, drop, 0, flen, $sformatf("rnd%0d", k));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
